decoder_arbiter: RTL and testbench

Round-robin arbiter that lets up to NUM_CH protocol decoders (UART and later SPI/I2C) share the analyzer's single byte-wide output path. Each decoder's one-cycle `out_valid` byte pulse is captured into a per-channel holding register. A fair round-robin scheduler forwards held bytes, tagged with the channel number, over a valid/ready interface to the readout logic. The block also generates each decoder's `detect_only` control from a channel-enable mask, and records sticky per-channel overflow flags.

---
 rtl/decoder_arbiter.sv | 132 +++++++++++++
 tb/tb_decoder_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_arbiter.sv
// Shares one byte-wide readout path between NUM_CH protocol decoders: per-channel
// single-byte holding registers feed a round-robin scheduler and a two-state output stage.
module decoder_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*NUM_CH-1:0]   in_data,
  input  logic [NUM_CH-1:0]     in_valid,
  input  logic [NUM_CH-1:0]     chan_en,
  output logic [NUM_CH-1:0]     detect_only,
  output logic [7:0]            out_data,
  output logic [CH_W-1:0]       out_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_CH-1:0]     overflow,
  input  logic                  clr_ovf
);

  // Handshake: a byte moves on every rising edge where out_valid && out_ready;
  // while out_valid=1 and out_ready=0, out_data/out_chan are held stable.
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t                   state_q, state_d;
  logic [NUM_CH-1:0][7:0]   hold_data_q, hold_data_d;
  logic [NUM_CH-1:0]        hold_vld_q, hold_vld_d;
  logic [NUM_CH-1:0]        eligible, drain, ovf_set;
  logic [NUM_CH-1:0]        ovf_q, ovf_d;
  logic [NUM_CH-1:0]        det_q;
  logic [CH_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]          grant_idx;
  logic                     grant_found;
  logic                     load;
  logic [7:0]               out_data_q, out_data_d;
  logic [CH_W-1:0]          out_chan_q, out_chan_d;

  // Disabled channels are never eligible, even if a byte is still held this cycle.
  assign eligible = hold_vld_q & chan_en;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = int'(rr_ptr_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!grant_found && eligible[c]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(c);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_EMPTY: if (grant_found) load = 1'b1;
      ST_FULL: begin
        if (out_ready) begin
          if (grant_found) load = 1'b1;
          else             state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (load) begin
      state_d    = ST_FULL;
      out_data_d = hold_data_q[grant_idx];
      out_chan_d = grant_idx;
      rr_ptr_d   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // A channel drained by this cycle's grant may accept a new byte in the same cycle.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    drain       = '0;
    ovf_set     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drain[i] = load && (grant_idx == CH_W'(i));
      if (!chan_en[i]) begin
        hold_vld_d[i] = 1'b0;
      end else begin
        if (drain[i]) hold_vld_d[i] = 1'b0;
        if (in_valid[i]) begin
          if (!hold_vld_q[i] || drain[i]) begin
            hold_vld_d[i]  = 1'b1;
            hold_data_d[i] = in_data[8*i +: 8];
          end else begin
            ovf_set[i] = 1'b1;
          end
        end
      end
    end
    ovf_d = (clr_ovf ? '0 : ovf_q) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= '0;
      hold_vld_q  <= '0;
      ovf_q       <= '0;
      det_q       <= '1;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_vld_q  <= hold_vld_d;
      ovf_q       <= ovf_d;
      det_q       <= ~chan_en;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid   = (state_q == ST_FULL);
  assign out_data    = out_data_q;
  assign out_chan    = out_chan_q;
  assign overflow    = ovf_q;
  assign detect_only = det_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
// Bench for decoder_arbiter: directed scenarios plus random traffic, checked by a
// scoreboard fed from a channel-level reference model of holding slots and grants.
module tb_decoder_arbiter;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int W      = CH_W + 8;

  logic                clk;
  logic                rst_n;
  logic [8*NUM_CH-1:0] in_data;
  logic [NUM_CH-1:0]   in_valid;
  logic [NUM_CH-1:0]   chan_en;
  logic [NUM_CH-1:0]   detect_only;
  logic [7:0]          out_data;
  logic [CH_W-1:0]     out_chan;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_CH-1:0]   overflow;
  logic                clr_ovf;

  decoder_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .chan_en(chan_en), .detect_only(detect_only), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: one slot per channel, a pointer, and whether the output holds a byte.
  logic [NUM_CH-1:0] m_vld;
  logic [7:0]        m_dat[NUM_CH];
  int                m_rr;
  logic              m_out_vld;
  logic [NUM_CH-1:0] m_ovf;
  logic [NUM_CH-1:0] m_det;
  logic [NUM_CH-1:0] m_new_ovf;
  int                m_g;
  logic              stall_prev;
  logic [W-1:0]      stall_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_vld = '0;
    for (int c = 0; c < NUM_CH; c++) m_dat[c] = 8'h00;
    m_rr = 0;
    m_out_vld = 1'b0;
    m_ovf = '0;
    m_det = '1;
    exp_q.delete();
    stall_prev = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_g = -1;
      if (!m_out_vld || out_ready) begin
        for (int k = 0; k < NUM_CH; k++)
          if (m_g < 0 && chan_en[(m_rr + k) % NUM_CH] && m_vld[(m_rr + k) % NUM_CH])
            m_g = (m_rr + k) % NUM_CH;
        if (m_g >= 0) begin
          exp_q.push_back({CH_W'(m_g), m_dat[m_g]});
          m_vld[m_g] = 1'b0;
          m_rr = (m_g + 1) % NUM_CH;
          m_out_vld = 1'b1;
        end else begin
          m_out_vld = 1'b0;
        end
      end
      m_new_ovf = clr_ovf ? '0 : m_ovf;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!chan_en[c]) m_vld[c] = 1'b0;
        else if (in_valid[c]) begin
          if (!m_vld[c]) begin
            m_vld[c] = 1'b1;
            m_dat[c] = in_data[8*c +: 8];
          end else begin
            m_new_ovf[c] = 1'b1;
          end
        end
      end
      m_ovf = m_new_ovf;
      m_det = ~chan_en;
    end
  end

  // Monitor: samples at the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(m_out_vld));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("detect_only", 32'(detect_only), 32'(m_det));
      if (stall_prev && out_valid)
        chk("stall_hold", 32'({out_chan, out_data}), 32'(stall_val));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got chan %0d data %0h expected no byte", out_chan, out_data);
        end else begin
          chk("out_byte", 32'({out_chan, out_data}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_chan, out_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] mask, input logic [8*NUM_CH-1:0] data);
    in_valid = mask;
    in_data  = data;
    tick(1);
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_detect_only", 32'(detect_only), 32'hF);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_data = '0;
    in_valid = '0;
    chan_en = '0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    #1;
    do_reset();

    // Single channel latency and one-cycle output.
    chan_en = 4'b0001;
    out_ready = 1'b1;
    pulse(4'b0001, 32'h0000_0055);
    @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h55);
    chk("lat_chan", 32'(out_chan), 32'd0);
    @(negedge clk);
    chk("lat_one_cycle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;

    // Fairness, twice so the pointer wraps.
    chan_en = 4'hF;
    repeat (2) begin
      out_ready = 1'b0;
      pulse(4'hF, 32'hA3A2_A1A0);
      tick(3);
      out_ready = 1'b1;
      tick(6);
    end

    // Rotation: grant to ch1 leaves the pointer at 2, so ch3 wins over ch0.
    pulse(4'b0010, 32'h0000_B100);
    tick(3);
    out_ready = 1'b0;
    pulse(4'b1001, 32'hC300_00C0);
    @(negedge clk);
    @(negedge clk);
    chk("rot_first", 32'(out_chan), 32'd3);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    tick(4);

    // Overflow on a stalled output, clear, then set coinciding with clear.
    out_ready = 1'b0;
    pulse(4'b0100, 32'h0033_0000);
    tick(2);
    pulse(4'b0010, 32'h0000_1100);
    pulse(4'b0010, 32'h0000_2200);
    @(negedge clk);
    chk("ovf_set", 32'(overflow[1]), 32'd1);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    tick(3);
    out_ready = 1'b0;
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 32'(overflow), 32'd0);
    @(posedge clk);
    #2;
    pulse(4'b0100, 32'h0044_0000);
    tick(2);
    pulse(4'b0010, 32'h0000_AA00);
    clr_ovf = 1'b1;
    pulse(4'b0010, 32'h0000_BB00);
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", 32'(overflow[1]), 32'd1);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    tick(4);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;

    // Disable flushes a held byte and ignores later strobes.
    out_ready = 1'b0;
    pulse(4'b0100, 32'h0055_0000);
    tick(2);
    pulse(4'b1000, 32'h7700_0000);
    tick(1);
    chan_en = 4'b0111;
    tick(1);
    @(negedge clk);
    chk("dis_detect", 32'(detect_only[3]), 32'd1);
    @(posedge clk);
    #2;
    pulse(4'b1000, 32'h8800_0000);
    @(negedge clk);
    chk("dis_no_ovf", 32'(overflow[3]), 32'd0);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    tick(4);
    chan_en = 4'hF;
    tick(2);

    // Random traffic with a reset in the middle of it.
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) chan_en = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
      for (int c = 0; c < NUM_CH; c++) in_data[8*c +: 8] = 8'($urandom);
      in_valid  = NUM_CH'($urandom) & NUM_CH'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      if (i == 300) do_reset();
      else tick(1);
    end

    // Drain everything still pending.
    in_valid = '0;
    clr_ovf = 1'b0;
    chan_en = '1;
    out_ready = 1'b1;
    tick(12);
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
